// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, reserved address, FSM encoding.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    // Writes here are forwarded; the memory itself discards them.
    localparam logic [7:0] PROTECT_ADDR = 8'hFF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request picker. Define DMEM_ARB_RR_EN for round-robin on contention;
// otherwise port 0 has fixed priority.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1)
            grant_id = ~last_grant;
        else
            grant_id = req1 & ~req0;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1 & ~req0;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the load/store unit (port 0) and debug/DMA (port 1).
// Arbitration policy selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    logic [1:0]        state;
    logic              last_grant;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_valid;
    logic              grant_id;

    dmem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state      <= ST_ACCESS;
                        last_grant <= grant_id;
                        lat_id     <= grant_id;
                        lat_we     <= grant_id ? we1    : we0;
                        lat_addr   <= grant_id ? addr1  : addr0;
                        lat_wdata  <= grant_id ? wdata1 : wdata0;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_DONE;
                    if (!lat_we) begin
                        if (lat_id)
                            rdata1 <= mem_rd;
                        else
                            rdata0 <= mem_rd;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset kills a pending write.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (state == ST_ACCESS) begin
            mem_a  = lat_addr;
            mem_wd = lat_wdata;
            mem_we = lat_we;
        end
    end

    assign ack0 = (state == ST_DONE) && !lat_id;
    assign ack1 = (state == ST_DONE) &&  lat_id;
    assign busy = (state != ST_IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 256 x 8 data memory between the core load/store unit (port 0) and a debug/DMA requester (port 1). It serialises requests, drives the memory address, write-data and write-enable lines, captures asynchronous read data, and returns it to the winning requester with a one-cycle acknowledge. Sits directly in front of the data memory; the memory's read output feeds back into this block.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request, held until matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  access address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read result, valid with ack, held until next read ack on that port
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory combinational read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req high, select winner, latch its we/addr/wdata and port id, go ACCESS. Else stay.
- ACCESS (one cycle): mem_a = latched addr, mem_wd = latched wdata, mem_we = latched we. At the clock edge ending ACCESS the memory performs the write; for reads, mem_rd is captured into rdata of the winning port. Go DONE.
- DONE (one cycle): winner's ack high; no arbitration; go IDLE. Requester drops req (or presents a new request) in DONE; a request still high in IDLE is treated as new.
- Outside ACCESS: mem_we = 0, mem_a = 0, mem_wd = 0.
- Writes to address 0xFF are forwarded and acked normally; the memory discards them (reserved address). Reads of 0xFF return mem_rd unchanged.
- Write accesses leave rdata of that port unchanged.
- Arbitration: see Configuration. last_grant register records the winner at each IDLE->ACCESS transition.

## Timing
- Request first sampled high at edge ending cycle N (IDLE) -> ACCESS in N+1 -> ack in N+2 -> IDLE in N+3. Latency 2 cycles from grant to ack; max throughput one access per 3 cycles.
- Losing requester waits; worst case one full access (3 cycles) under round-robin.
- Reset values: state IDLE, ack0/ack1 0, rdata0/rdata1 0, mem_a/mem_wd 0, mem_we 0, busy 0, last_grant = 1 (port 0 wins first contention).
- Reset asserted mid-ACCESS: mem_we drops immediately (combinational from state), write not performed, no ack issued; requester must re-request after release.
- Request dropped before ack (protocol violation): access still completes and acks; not checked.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin — on simultaneous req0/req1 grant the port not equal to last_grant.
- Not defined: fixed priority — port 0 always wins simultaneous requests; last_grant still maintained but unused.

## Structure
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, PROTECT_ADDR = 8'hFF, FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
- One sub-module: dmem_arb_pick — combinational two-way picker (req0, req1, last_grant -> grant_valid, grant_id), holding the DMEM_ARB_RR_EN selection.

## Test plan
- Port 0 writes 0x5A to 0x10, then reads 0x10 -> ack0 two cycles after each grant, rdata0 = 0x5A, mem_we high exactly one cycle.
- Port 1 read of 0x10 while port 0 idle -> rdata1 = 0x5A, rdata0 unchanged, ack0 never high.
- req0 and req1 high together repeatedly (RR enabled) -> grants alternate 0,1,0,1; with macro undefined -> port 0 always first, port 1 served only when req0 low.
- Port 1 writes 0x33 to 0xFF, then reads 0xFF -> ack1 issued for both, rdata1 = 0x00 (memory unmodified after reset).
- rst pulsed low during ACCESS of a write 0x77 to 0x20 -> no ack, busy 0, subsequent read of 0x20 returns 0x00.
- Back-to-back: req0 held through DONE with new address -> second access begins in IDLE cycle N+3, ack at N+5.
